// File: rtl/sram_march_bist_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_march_bist_ctrl                                       |
// | Description : March C- BIST controller for a single-port SRAM macro.     |
// |               Drives the macro's A_BIST_* side one operation per cycle,  |
// |               checks read data one cycle later, and reports pass/fail    |
// |               with the address and element of the first mismatch.        |
// | Option      : BIST_STOP_ON_FAIL_EN - when defined, the first mismatch    |
// |               ends the run at once (DONE on the comparing edge).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   A_CLK         in   clock (same clock as the macro's A_BIST_CLK)        |
// |   A_RST_N       in   asynchronous active-low reset                        |
// |   A_START       in   start request, accepted in IDLE or DONE             |
// |   A_BUSY        out  high while RUN or DRAIN                             |
// |   A_DONE        out  high in DONE (sticky)                               |
// |   A_FAIL        out  sticky mismatch flag                                |
// |   A_FAIL_ADDR   out  address of first mismatch                           |
// |   A_FAIL_ELEM   out  March element (0-5) of first mismatch              |
// |   A_BIST_EN     out  macro mux select (BIST path)                        |
// |   A_BIST_ADDR   out  macro address                                       |
// |   A_BIST_DIN    out  macro write data (all-0 / all-1)                    |
// |   A_BIST_BM     out  macro bit mask (all-1 while busy)                   |
// |   A_BIST_MEN    out  macro enable                                        |
// |   A_BIST_WEN    out  macro write enable                                  |
// |   A_BIST_REN    out  macro read enable                                   |
// |   A_BIST_DOUT   in   macro read data (valid the cycle after a read)      |
// +--------------------------------------------------------------------------+
module sram_march_bist_ctrl #(
  parameter int P_DATA_WIDTH = 24,
  parameter int P_ADDR_WIDTH = 14
) (
  input  logic                    A_CLK,
  input  logic                    A_RST_N,
  input  logic                    A_START,
  output logic                    A_BUSY,
  output logic                    A_DONE,
  output logic                    A_FAIL,
  output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
  output logic [2:0]              A_FAIL_ELEM,
  output logic                    A_BIST_EN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  input  logic [P_DATA_WIDTH-1:0] A_BIST_DOUT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [P_ADDR_WIDTH-1:0] c_addr_max  = '1;
  localparam logic [P_ADDR_WIDTH-1:0] c_addr_one  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]              c_elem_last = 3'd5;

  state_t                  r_state, w_state_nxt;
  // Coordinates of the operation currently presented to the macro
  logic [2:0]              r_elem, w_elem_nxt;
  logic                    r_phase, w_phase_nxt;
  logic [P_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;

  logic                    r_busy, r_done, r_men, r_wen, r_ren;
  logic [P_DATA_WIDTH-1:0] r_din;
  // Read pipeline: one stage matches the macro's one-cycle read latency
  logic                    r_dv, r_dexp;
  logic [P_ADDR_WIDTH-1:0] r_daddr;
  logic [2:0]              r_delem;
  logic                    r_fail;
  logic [P_ADDR_WIDTH-1:0] r_fail_addr;
  logic [2:0]              r_fail_elem;

  logic w_desc, w_last_phase, w_at_term, w_mismatch;
  logic w_issue, w_start_ok, w_flush, w_busy_nxt;
  logic w_nxt_read, w_nxt_write, w_nxt_bit;

  // Phase 0 of E1..E5 is the read; E0 is a single write
  function automatic logic f_is_read(input logic [2:0] elem, input logic phase);
    return (elem != 3'd0) && !phase;
  endfunction

  // Data value of an operation: read-expected or write data bit
  function automatic logic f_data(input logic [2:0] elem, input logic phase);
    logic v;
    v = 1'b0;
    case (elem)
      3'd1, 3'd3: v = phase;   // r0 then w1
      3'd2, 3'd4: v = ~phase;  // r1 then w0
      default:    v = 1'b0;    // E0 w0, E5 r0
    endcase
    return v;
  endfunction

  always_comb begin
    w_desc       = (r_elem == 3'd3) || (r_elem == 3'd4);
    w_last_phase = (r_elem == 3'd0) || (r_elem == c_elem_last) || r_phase;
    w_at_term    = w_desc ? (r_addr == '0) : (r_addr == c_addr_max);
    w_mismatch   = r_dv && (A_BIST_DOUT != {P_DATA_WIDTH{r_dexp}});

    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_phase_nxt = r_phase;
    w_addr_nxt  = r_addr;
    w_issue     = 1'b0;
    w_start_ok  = 1'b0;
    w_flush     = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (A_START) begin
          w_state_nxt = S_RUN;
          w_elem_nxt  = 3'd0;
          w_phase_nxt = 1'b0;
          w_addr_nxt  = '0;
          w_issue     = 1'b1;
          w_start_ok  = 1'b1;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (!w_last_phase) begin
          w_phase_nxt = 1'b1;
        end else if (!w_at_term) begin
          w_phase_nxt = 1'b0;
          w_addr_nxt  = w_desc ? (r_addr - c_addr_one) : (r_addr + c_addr_one);
        end else if (r_elem == c_elem_last) begin
          w_state_nxt = S_DRAIN;
          w_issue     = 1'b0;
          w_addr_nxt  = '0;
        end else begin
          // Next element starts with no idle cycle; E3/E4 run downwards
          w_elem_nxt  = r_elem + 3'd1;
          w_phase_nxt = 1'b0;
          w_addr_nxt  = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? c_addr_max : '0;
        end
`ifdef BIST_STOP_ON_FAIL_EN
        if (w_mismatch) begin
          w_state_nxt = S_DONE;
          w_issue     = 1'b0;
          w_addr_nxt  = '0;
          w_flush     = 1'b1;  // discard the read already in flight
        end
`endif
      end
      S_DRAIN: begin
        w_state_nxt = S_DONE;
        w_addr_nxt  = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    w_nxt_read  = w_issue && f_is_read(w_elem_nxt, w_phase_nxt);
    w_nxt_write = w_issue && !f_is_read(w_elem_nxt, w_phase_nxt);
    w_nxt_bit   = w_nxt_write && f_data(w_elem_nxt, w_phase_nxt);
  end

  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      r_elem      <= 3'd0;
      r_phase     <= 1'b0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_men       <= 1'b0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_din       <= '0;
      r_dv        <= 1'b0;
      r_dexp      <= 1'b0;
      r_daddr     <= '0;
      r_delem     <= 3'd0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
    end else begin
      r_elem  <= w_elem_nxt;
      r_phase <= w_phase_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      r_men   <= w_issue;
      r_wen   <= w_nxt_write;
      r_ren   <= w_nxt_read;
      r_din   <= {P_DATA_WIDTH{w_nxt_bit}};

      r_dv    <= r_ren && !w_flush;
      r_dexp  <= f_data(r_elem, r_phase);
      r_daddr <= r_addr;
      r_delem <= r_elem;

      if (w_start_ok) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_elem <= 3'd0;
      end else if (w_mismatch) begin
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_fail_addr <= r_daddr;
          r_fail_elem <= r_delem;
        end
      end
    end
  end

  assign A_BUSY      = r_busy;
  assign A_DONE      = r_done;
  assign A_FAIL      = r_fail;
  assign A_FAIL_ADDR = r_fail_addr;
  assign A_FAIL_ELEM = r_fail_elem;
  assign A_BIST_EN   = r_busy;
  assign A_BIST_ADDR = r_addr;
  assign A_BIST_DIN  = r_din;
  assign A_BIST_BM   = {P_DATA_WIDTH{r_busy}};
  assign A_BIST_MEN  = r_men;
  assign A_BIST_WEN  = r_wen;
  assign A_BIST_REN  = r_ren;

endmodule
`default_nettype wire
